// File: rtl/mc_chroma_ip_ctrl.sv
// ---------------------------------------------------------------------------
// mc_chroma_ip_ctrl
//
// Sequencer for the 4x4 chroma fractional interpolator (7-pixel rows, 4-tap
// separable filter). One block request runs the U component and then the V
// component. For each component the controller:
//   - pulses ip_blk_start_o,
//   - reads 7 reference rows,
//   - forwards those rows to the interpolator,
//   - writes the 4 interpolated rows into the prediction buffer.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start_i           block request (taken only while ready_o=1)
//   frac_i            MV fraction {y[2:0], x[2:0]}
//   base_i            first reference row of the U plane
//   ready_o           idle / able to accept start_i
//   done_o            one-cycle pulse at the end of the V component
//   ref_rd_o          reference buffer read enable
//   ref_addr_o        reference buffer row address
//   ref_data_i        reference row, valid one cycle after ref_rd_o
//   ip_blk_start_o    block-start pulse to the interpolator
//   ip_frac_o         latched fraction to the interpolator
//   ip_ref_valid_o    row valid to the interpolator
//   ip_ref_o          row pixels p0..p6 to the interpolator
//   ip_frac_valid_i   interpolated row valid from the interpolator
//   ip_frac_i         interpolated row
//   pred_wr_o         prediction buffer write enable
//   pred_addr_o       prediction buffer address {comp, row[1:0]}
//   pred_data_o       prediction row
// ---------------------------------------------------------------------------
module mc_chroma_ip_ctrl #(
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_W      = 6,
    parameter int V_OFFSET    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [5:0]               frac_i,
    input  logic [ADDR_W-1:0]        base_i,
    output logic                     ready_o,
    output logic                     done_o,
    output logic                     ref_rd_o,
    output logic [ADDR_W-1:0]        ref_addr_o,
    input  logic [7*PIXEL_WIDTH-1:0] ref_data_i,
    output logic                     ip_blk_start_o,
    output logic [5:0]               ip_frac_o,
    output logic                     ip_ref_valid_o,
    output logic [7*PIXEL_WIDTH-1:0] ip_ref_o,
    input  logic                     ip_frac_valid_i,
    input  logic [4*PIXEL_WIDTH-1:0] ip_frac_i,
    output logic                     pred_wr_o,
    output logic [2:0]               pred_addr_o,
    output logic [4*PIXEL_WIDTH-1:0] pred_data_o
);

    localparam logic [ADDR_W-1:0] V_OFF     = ADDR_W'(V_OFFSET);
    localparam logic [2:0]        LAST_READ = 3'd6;
    localparam logic [2:0]        ROWS_OUT  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        row_base;
    logic                     comp;       // 0 = U, 1 = V
    logic [2:0]               rcnt;       // reference rows issued
    logic [2:0]               ocnt;       // interpolated rows written, saturates at 4
    logic [7*PIXEL_WIDTH-1:0] ref_hold;   // last valid reference row

    logic                     accept;
    logic                     row_take;
    logic                     rows_done;
    logic [ADDR_W-1:0]        comp_base;

    always_comb begin
        accept    = start_i && ready_o;
        // Interpolated rows may arrive while rows are still being fetched,
        // so both FETCH and DRAIN count them; extras past the 4th are dropped.
        row_take  = ip_frac_valid_i && (ocnt != ROWS_OUT) &&
                    ((state == S_FETCH) || (state == S_DRAIN));
        rows_done = (ocnt == ROWS_OUT) || (row_take && (ocnt == ROWS_OUT - 3'd1));
        // Address arithmetic wraps modulo 2^ADDR_W by construction.
        comp_base = comp ? (row_base + V_OFF) : row_base;
    end

    // Rows are forwarded combinationally so they line up with ip_ref_valid_o;
    // between rows the interpolator sees the last row it was given.
    assign ip_ref_o = ip_ref_valid_o ? ref_data_i : ref_hold;

    // NOTE: every register in this block uses non-blocking assignment so that
    // all right-hand sides see pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            row_base       <= '0;
            comp           <= 1'b0;
            rcnt           <= '0;
            ocnt           <= '0;
            ref_hold       <= '0;
            ready_o        <= 1'b1;
            done_o         <= 1'b0;
            ref_rd_o       <= 1'b0;
            ref_addr_o     <= '0;
            ip_blk_start_o <= 1'b0;
            ip_frac_o      <= '0;
            ip_ref_valid_o <= 1'b0;
            pred_wr_o      <= 1'b0;
            pred_addr_o    <= '0;
            pred_data_o    <= '0;
        end else begin
            // Single-cycle pulses default low.
            ip_blk_start_o <= 1'b0;
            done_o         <= 1'b0;
            pred_wr_o      <= 1'b0;

            ip_ref_valid_o <= ref_rd_o;
            if (ip_ref_valid_o) begin
                ref_hold <= ref_data_i;
            end

            if (row_take) begin
                pred_wr_o   <= 1'b1;
                pred_data_o <= ip_frac_i;
                pred_addr_o <= {comp, ocnt[1:0]};
                ocnt        <= ocnt + 3'd1;
            end

            unique case (state)
                // DONE behaves like IDLE for acceptance so a request held
                // across done_o starts the next block without a gap.
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        ip_frac_o      <= frac_i;
                        row_base       <= base_i;
                        comp           <= 1'b0;
                        ready_o        <= 1'b0;
                        ip_blk_start_o <= 1'b1;
                        state          <= S_START;
                    end else begin
                        ready_o <= 1'b1;
                        state   <= S_IDLE;
                    end
                end

                S_START: begin
                    rcnt       <= '0;
                    ocnt       <= '0;
                    ref_rd_o   <= 1'b1;
                    ref_addr_o <= comp_base;
                    state      <= S_FETCH;
                end

                S_FETCH: begin
                    if (rcnt == LAST_READ) begin
                        ref_rd_o <= 1'b0;
                        state    <= S_DRAIN;
                    end else begin
                        rcnt       <= rcnt + 3'd1;
                        ref_addr_o <= ref_addr_o + ADDR_W'(1);
                    end
                end

                S_DRAIN: begin
                    if (rows_done) begin
                        if (!comp) begin
                            comp           <= 1'b1;
                            ip_blk_start_o <= 1'b1;
                            state          <= S_START;
                        end else begin
                            done_o  <= 1'b1;
                            ready_o <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mc_chroma_ip_ctrl.md
Name: mc_chroma_ip_ctrl

Overview:
Sequencer for the 4x4 chroma fractional interpolator (7-pixel-wide, 4-tap separable filter). It accepts one chroma block request carrying a MV fraction and a reference-buffer base address. It then runs the U component and the V component back to back. For each component it issues 7 reference-row reads, feeds those rows to the interpolator with a block-start pulse, and collects 4 interpolated rows into the prediction buffer. It sits between the MC reference fetch buffer and the chroma interpolator inside the rec_mc path.

Parameters:
PIXEL_WIDTH, 8, bits per chroma sample
ADDR_W, 6, reference buffer row-address width
V_OFFSET, 32, row offset of the V plane from the U plane in the reference buffer

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_i  in  1  block request; accepted only when ready_o=1
frac_i  in  6  MV fraction, [2:0]=x, [5:3]=y
base_i  in  ADDR_W  first reference row address of the U plane
ready_o  out  1  controller idle, can accept start_i
done_o  out  1  one-cycle pulse after the last V row is written
ref_rd_o  out  1  reference buffer read enable
ref_addr_o  out  ADDR_W  reference buffer row address
ref_data_i  in  7*PIXEL_WIDTH  row data, valid 1 cycle after ref_rd_o; p0 in MSBs
ip_blk_start_o  out  1  block-start pulse to the interpolator
ip_frac_o  out  6  latched fraction to the interpolator
ip_ref_valid_o  out  1  row valid to the interpolator
ip_ref_o  out  7*PIXEL_WIDTH  row pixels p0..p6 to the interpolator
ip_frac_valid_i  in  1  interpolated row valid from the interpolator
ip_frac_i  in  4*PIXEL_WIDTH  interpolated row
pred_wr_o  out  1  prediction buffer write enable
pred_addr_o  out  3  {comp, row[1:0]}; comp 0=U, 1=V
pred_data_o  out  4*PIXEL_WIDTH  prediction row

Behaviour:
- Reset: state IDLE; ready_o=1; every other output is 0. Reset mid-operation aborts the block immediately, and no done_o is produced.
- FSM states: IDLE, START, FETCH, DRAIN, DONE.
- IDLE:
  - ready_o=1.
  - On start_i, latch frac_i into ip_frac_o and base_i into the row base, set comp=0, and go to START.
  - start_i in any other state is ignored.
- START: assert ip_blk_start_o for one cycle; clear the read counter rcnt and the output counter ocnt; go to FETCH.
- FETCH:
  - ref_rd_o=1 for exactly 7 consecutive cycles.
  - ref_addr_o = base + comp*V_OFFSET + rcnt, with rcnt = 0..6, computed modulo 2^ADDR_W (wrap allowed).
  - Go to DRAIN after rcnt=6.
- Data path:
  - ip_ref_valid_o is ref_rd_o delayed by 1 cycle.
  - ip_ref_o is ref_data_i passed combinationally, so it is aligned with ip_ref_valid_o.
  - ip_ref_o is held at its last value when ip_ref_valid_o=0.
- DRAIN:
  - Wait for ip_frac_valid_i. Each pulse (it can arrive during FETCH too, so count it in both states) drives a registered write one cycle later:
    - pred_wr_o=1
    - pred_data_o=ip_frac_i
    - pred_addr_o={comp, ocnt}
    - then ocnt increments.
  - When the 4th row is counted and comp=0: set comp=1 and go to START.
  - When the 4th row is counted and comp=1: go to DONE.
- ocnt rules: ocnt saturates at 4. Any ip_frac_valid_i after the 4th row of a component is ignored, with no write.
- DONE: done_o=1 for one cycle, then IDLE; ready_o returns to 1 in the same cycle done_o is high.
- Latency: start_i accept to the first ref_rd_o is 2 cycles (IDLE->START->FETCH). A back-to-back start_i accepted in the done_o cycle is legal.
- ip_frac_o is stable from START of U through DONE.

Test Plan:
- Reset, then start_i with frac_i=6'b010_011, base_i=5 -> ip_blk_start_o at cycle+1; ref_addr_o 5..11 on cycles +2..+8; second ip_blk_start_o for V, then ref_addr_o 37..43; ip_frac_o=6'b010_011 throughout.
- Interpolator model returns 4 rows per component -> pred_addr_o sequence 0,1,2,3,4,5,6,7 with matching data; exactly one done_o pulse after pred_addr_o=7.
- base_i=60, ADDR_W=6 -> U addresses 60,61,62,63,0,1,2; V addresses 28..34 (wrap).
- start_i asserted while busy, and a 5th ip_frac_valid_i in a component -> no restart; no extra pred_wr_o; addresses unchanged.
- rst pulsed in the middle of V FETCH -> all outputs 0 on the next cycle, ready_o=1, no done_o; a new start_i then completes normally.
- start_i held high across done_o -> the new block is accepted in the done_o cycle; its first ref_rd_o comes 2 cycles later.
